// File: rtl/conv_mem_host.sv
// Memory host for the convolution engine: loads the image, kicks the engine, serves its
// image/layer traffic, then streams both layer banks out over a valid/ready port.
`timescale 1ns/1ps
module conv_mem_host #(
  parameter int unsigned IMG_AW       = 12,
  parameter int unsigned L1_AW        = 10,
  parameter int unsigned DW           = 20,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              load_valid,
  input  logic [DW-1:0]     load_data,
  output logic              load_ready,
  output logic              ready,
  input  logic              busy,
  input  logic [IMG_AW-1:0] iaddr,
  output logic [DW-1:0]     idata,
  input  logic              cwr,
  input  logic [IMG_AW-1:0] caddr_wr,
  input  logic [DW-1:0]     cdata_wr,
  input  logic              crd,
  input  logic [IMG_AW-1:0] caddr_rd,
  output logic [DW-1:0]     cdata_rd,
  input  logic [2:0]        csel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic              out_sel,
  output logic [IMG_AW-1:0] out_addr,
  output logic              done,
  output logic              err
);

  localparam int unsigned ImgDepth = 1 << IMG_AW;
  localparam int unsigned L1Depth  = 1 << L1_AW;
  localparam int unsigned TW       = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle, StLoad, StKick, StWaitBusy, StRun, StDumpL0, StDumpL1, StDone
  } state_e;

  logic [DW-1:0] r_img [ImgDepth];
  logic [DW-1:0] r_l0  [ImgDepth];
  logic [DW-1:0] r_l1  [L1Depth];

  state_e            r_state, w_state_nxt;
  logic [IMG_AW-1:0] r_addr, w_addr_nxt;
  logic [TW-1:0]     r_tmo, w_tmo_nxt;
  logic              r_err, w_err_nxt;

  logic w_sel_l0, w_sel_l1, w_serve, w_l1_hi_wr, w_l1_hi_rd;
  logic w_proto_err, w_l0_we, w_l1_we, w_load_fire, w_dump;

  assign w_sel_l0    = (csel == 3'd1);
  assign w_sel_l1    = (csel == 3'd3);
  assign w_serve     = (r_state == StWaitBusy) || (r_state == StRun);
  assign w_l1_hi_wr  = (caddr_wr[IMG_AW-1:L1_AW] != '0);
  assign w_l1_hi_rd  = (caddr_rd[IMG_AW-1:L1_AW] != '0);
  assign w_dump      = (r_state == StDumpL0) || (r_state == StDumpL1);
  assign w_load_fire = (r_state == StLoad) && load_valid;

  // A simultaneous read/write is flagged but the write still lands.
  assign w_proto_err = ((cwr || crd) && !(w_sel_l0 || w_sel_l1))
                     || (cwr && crd)
                     || (w_sel_l1 && ((cwr && w_l1_hi_wr) || (crd && w_l1_hi_rd)))
                     || ((cwr || crd) && !w_serve);

  assign w_l0_we = cwr && w_serve && w_sel_l0;
  assign w_l1_we = cwr && w_serve && w_sel_l1;

  assign idata      = r_img[iaddr];
  assign load_ready = (r_state == StLoad);
  assign ready      = (r_state == StKick);
  assign out_valid  = w_dump;
  assign done       = (r_state == StDone);
  assign err        = r_err;

  always_comb begin
    cdata_rd = '0;
    if (crd) begin
      if (w_sel_l0) begin
        cdata_rd = r_l0[caddr_rd];
      end else if (w_sel_l1) begin
        cdata_rd = r_l1[caddr_rd[L1_AW-1:0]];
      end
    end
  end

  always_comb begin
    out_data = '0;
    out_sel  = 1'b0;
    out_addr = '0;
    if (r_state == StDumpL0) begin
      out_data = r_l0[r_addr];
      out_addr = r_addr;
    end else if (r_state == StDumpL1) begin
      out_data = r_l1[r_addr[L1_AW-1:0]];
      out_sel  = 1'b1;
      out_addr = {{(IMG_AW-L1_AW){1'b0}}, r_addr[L1_AW-1:0]};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_tmo_nxt   = r_tmo;
    w_err_nxt   = r_err || w_proto_err;
    unique case (r_state)
      StIdle, StDone: begin
        if (start) begin
          w_state_nxt = StLoad;
          w_addr_nxt  = '0;
          w_err_nxt   = w_proto_err;
        end
      end
      StLoad: begin
        if (load_valid) begin
          w_addr_nxt = r_addr + IMG_AW'(1);
          if (r_addr == '1) w_state_nxt = StKick;
        end
      end
      StKick: begin
        w_state_nxt = StWaitBusy;
        w_tmo_nxt   = '0;
      end
      StWaitBusy: begin
        if (busy) begin
          w_state_nxt = StRun;
        end else if (r_tmo == TW'(BUSY_TIMEOUT - 1)) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = StDone;
        end else begin
          w_tmo_nxt = r_tmo + TW'(1);
        end
      end
      StRun: begin
        if (!busy) begin
          w_state_nxt = StDumpL0;
          w_addr_nxt  = '0;
        end
      end
      StDumpL0: begin
        if (out_ready) begin
          if (r_addr == '1) begin
            w_state_nxt = StDumpL1;
            w_addr_nxt  = '0;
          end else begin
            w_addr_nxt = r_addr + IMG_AW'(1);
          end
        end
      end
      StDumpL1: begin
        if (out_ready) begin
          if (r_addr[L1_AW-1:0] == '1) begin
            w_state_nxt = StDone;
            w_addr_nxt  = '0;
          end else begin
            w_addr_nxt = r_addr + IMG_AW'(1);
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_addr  <= '0;
      r_tmo   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_tmo   <= w_tmo_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Memories are deliberately outside the reset domain: contents survive reset.
  always_ff @(posedge clk) begin
    if (w_load_fire) r_img[r_addr] <= load_data;
    if (w_l0_we)     r_l0[caddr_wr] <= cdata_wr;
    if (w_l1_we)     r_l1[caddr_wr[L1_AW-1:0]] <= cdata_wr;
  end

endmodule

// File: tb/tb_conv_mem_host.sv
// Directed bench for conv_mem_host: load/kick, serving, protocol errors, timeout,
// backpressured dump and reset during load.
`timescale 1ns/1ps
module tb_conv_mem_host;

  localparam int AW = 12;
  localparam int DW = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          load_valid = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic          load_ready, ready;
  logic          busy = 1'b0;
  logic [AW-1:0] iaddr = '0;
  logic [DW-1:0] idata;
  logic          cwr = 1'b0;
  logic [AW-1:0] caddr_wr = '0;
  logic [DW-1:0] cdata_wr = '0;
  logic          crd = 1'b0;
  logic [AW-1:0] caddr_rd = '0;
  logic [DW-1:0] cdata_rd;
  logic [2:0]    csel = 3'd1;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_sel;
  logic [AW-1:0] out_addr;
  logic          done, err;

  int n_err = 0;
  int n_chk = 0;

  conv_mem_host dut (
    .clk(clk), .reset(reset), .start(start), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready), .ready(ready), .busy(busy),
    .iaddr(iaddr), .idata(idata), .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sel(out_sel), .out_addr(out_addr), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Bank contents after test_fill and test_serve.
  function automatic logic [DW-1:0] exp_word(input int idx);
    int a;
    if (idx < 4096) begin
      a = idx;
      return (a == 'h123) ? 20'h0ABCD : DW'(a + 'h10000);
    end
    a = idx - 4096;
    return (a == 'h3FF) ? 20'hFEDCB : DW'(a + 'h80000);
  endfunction

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic load_words(input int n, input int off);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      if (load_ready !== 1'b1) bad++;
      load_valid = 1'b1;
      load_data  = DW'(i + off);
      @(negedge clk);
    end
    load_valid = 1'b0;
    n_chk++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL load_ready_during_load got=%0d low cycles required=0", bad);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_chk++;
    if ({load_ready, ready, out_valid, done, err} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags got=%b required=00000", {load_ready, ready, out_valid, done, err});
    end
    n_chk++;
    if ({out_data, out_sel, out_addr, cdata_rd} !== '0) begin
      n_err++;
      $display("FAIL reset_data got=%h/%b/%h/%h required=0", out_data, out_sel, out_addr, cdata_rd);
    end
    reset = 1'b0;
  endtask

  task automatic test_load_kick(input int off);
    int pulses;
    do_start();
    n_chk++;
    if ({err, done} !== 2'b00) begin
      n_err++;
      $display("FAIL start_clears got err,done=%b required=00", {err, done});
    end
    load_words(4096, off);
    n_chk++;
    if ({ready, load_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL kick_cycle got ready,load_ready=%b required=10", {ready, load_ready});
    end
    busy = 1'b1;
    pulses = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ready === 1'b1) pulses++;
    end
    n_chk++;
    if (pulses !== 1) begin
      n_err++;
      $display("FAIL ready_pulse got=%0d cycles required=1", pulses);
    end
  endtask

  task automatic test_fill();
    cwr = 1'b1;
    csel = 3'd1;
    for (int a = 0; a < 4096; a++) begin
      caddr_wr = AW'(a);
      cdata_wr = DW'(a + 'h10000);
      @(negedge clk);
    end
    csel = 3'd3;
    for (int a = 0; a < 1024; a++) begin
      caddr_wr = AW'(a);
      cdata_wr = DW'(a + 'h80000);
      @(negedge clk);
    end
    cwr = 1'b0;
    csel = 3'd1;
    n_chk++;
    if (err !== 1'b0) begin
      n_err++;
      $display("FAIL fill_err got=%b required=0", err);
    end
  endtask

  task automatic test_serve();
    iaddr = 12'h041;
    #1;
    n_chk++;
    if (idata !== 20'h00041) begin
      n_err++;
      $display("FAIL idata got=%h required=00041", idata);
    end
    cwr = 1'b1; csel = 3'd1; caddr_wr = 12'h123; cdata_wr = 20'h0ABCD;
    @(negedge clk);
    cwr = 1'b0; crd = 1'b1; caddr_rd = 12'h123;
    #1;
    n_chk++;
    if (cdata_rd !== 20'h0ABCD) begin
      n_err++;
      $display("FAIL l0_rw got=%h required=0abcd", cdata_rd);
    end
    crd = 1'b0; cwr = 1'b1; csel = 3'd3; caddr_wr = 12'h3FF; cdata_wr = 20'hFEDCB;
    @(negedge clk);
    cwr = 1'b0; crd = 1'b1; caddr_rd = 12'h3FF;
    #1;
    n_chk++;
    if (cdata_rd !== 20'hFEDCB) begin
      n_err++;
      $display("FAIL l1_rw got=%h required=fedcb", cdata_rd);
    end
    crd = 1'b0; csel = 3'd1;
    #1;
    n_chk++;
    if ({cdata_rd, err} !== {20'h0, 1'b0}) begin
      n_err++;
      $display("FAIL serve_idle got rd=%h err=%b required rd=0 err=0", cdata_rd, err);
    end
  endtask

  task automatic test_start_ignored();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n_chk++;
    if ({load_ready, ready, done} !== 3'b000) begin
      n_err++;
      $display("FAIL start_in_run got=%b required=000", {load_ready, ready, done});
    end
  endtask

  task automatic test_bad_csel();
    cwr = 1'b1; csel = 3'd2; caddr_wr = 12'h123; cdata_wr = 20'h11111;
    @(negedge clk);
    cwr = 1'b0;
    n_chk++;
    if (err !== 1'b1) begin
      n_err++;
      $display("FAIL bad_csel_err got=%b required=1", err);
    end
    crd = 1'b1; csel = 3'd1; caddr_rd = 12'h123;
    #1;
    n_chk++;
    if (cdata_rd !== 20'h0ABCD) begin
      n_err++;
      $display("FAIL bad_csel_l0 got=%h required=0abcd", cdata_rd);
    end
    csel = 3'd3;
    #1;
    n_chk++;
    if (cdata_rd !== 20'h80123) begin
      n_err++;
      $display("FAIL bad_csel_l1 got=%h required=80123", cdata_rd);
    end
    crd = 1'b0; csel = 3'd1;
  endtask

  task automatic test_dump();
    int idx = 0;
    logic [33:0] exp_v, got_v;
    logic [3:0] pat;
    pat = 4'b1001;
    busy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 25000 && idx < 5120; k++) begin
      out_ready = pat[3 - (k % 4)];
      exp_v = {1'b1, (idx >= 4096), AW'(idx % 4096), exp_word(idx)};
      got_v = {out_valid, out_sel, out_addr, out_data};
      n_chk++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL dump_word idx=%0d got=%h required=%h", idx, got_v, exp_v);
      end
      if (out_ready) idx++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    n_chk++;
    if (idx !== 5120) begin
      n_err++;
      $display("FAIL dump_count got=%0d required=5120", idx);
    end
    n_chk++;
    if ({done, out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL dump_done got done,valid=%b required=10", {done, out_valid});
    end
  endtask

  task automatic test_timeout();
    do_start();
    n_chk++;
    if ({err, done} !== 2'b00) begin
      n_err++;
      $display("FAIL restart_clears got err,done=%b required=00", {err, done});
    end
    load_words(4096, 0);
    busy = 1'b0;
    @(negedge clk);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      n_chk++;
      if ({done, err} !== {(i == 16), (i == 16)}) begin
        n_err++;
        $display("FAIL timeout cycle=%0d got done,err=%b required=%b", i, {done, err},
                 {(i == 16), (i == 16)});
      end
    end
  endtask

  task automatic test_reset_mid_load();
    do_start();
    load_words(100, 0);
    reset = 1'b1;
    #1;
    n_chk++;
    if ({load_ready, ready, out_valid, done, err} !== 5'b0) begin
      n_err++;
      $display("FAIL mid_reset got=%b required=00000", {load_ready, ready, out_valid, done, err});
    end
    @(negedge clk);
    n_chk++;
    if ({load_ready, ready, out_valid, done, err} !== 5'b0) begin
      n_err++;
      $display("FAIL mid_reset_next got=%b required=00000",
               {load_ready, ready, out_valid, done, err});
    end
    reset = 1'b0;
    test_load_kick(7);
    iaddr = 12'h000;
    #1;
    n_chk++;
    if (idata !== 20'h00007) begin
      n_err++;
      $display("FAIL reload_0 got=%h required=00007", idata);
    end
    iaddr = 12'h041;
    #1;
    n_chk++;
    if (idata !== 20'h00048) begin
      n_err++;
      $display("FAIL reload_41 got=%h required=00048", idata);
    end
    iaddr = 12'hFFF;
    #1;
    n_chk++;
    if (idata !== 20'h01006) begin
      n_err++;
      $display("FAIL reload_fff got=%h required=01006", idata);
    end
  endtask

  task automatic test_l1_upper();
    @(negedge clk);
    cwr = 1'b1; csel = 3'd3; caddr_wr = 12'h400; cdata_wr = 20'h33333;
    @(negedge clk);
    cwr = 1'b0; csel = 3'd1;
    n_chk++;
    if (err !== 1'b1) begin
      n_err++;
      $display("FAIL l1_upper_err got=%b required=1", err);
    end
  endtask

  task automatic test_rw_collision();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    test_load_kick(0);
    n_chk++;
    if (err !== 1'b0) begin
      n_err++;
      $display("FAIL pre_collision_err got=%b required=0", err);
    end
    cwr = 1'b1; crd = 1'b1; csel = 3'd1;
    caddr_wr = 12'h200; caddr_rd = 12'h200; cdata_wr = 20'h22222;
    #1;
    n_chk++;
    if (cdata_rd !== 20'h10200) begin
      n_err++;
      $display("FAIL collision_old got=%h required=10200", cdata_rd);
    end
    @(negedge clk);
    cwr = 1'b0;
    #1;
    n_chk++;
    if ({err, cdata_rd} !== {1'b1, 20'h22222}) begin
      n_err++;
      $display("FAIL collision_after got err=%b rd=%h required err=1 rd=22222", err, cdata_rd);
    end
    crd = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_kick(0);
    test_fill();
    test_serve();
    test_start_ignored();
    test_bad_csel();
    test_dump();
    test_timeout();
    test_reset_mid_load();
    test_l1_upper();
    test_rw_collision();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
